// File: rtl/blink_seq_pkg.sv
// Shared types and helpers for the LED blink sequencer.
package blink_seq_pkg;

    // FSM encoding; S_BAD is never entered and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_BAD   = 2'b11
    } state_e;

    // Mod-4 step of the tap select: dir=0 counts up, dir=1 counts down.
    function automatic logic [1:0] sel_next(input logic [1:0] sel, input logic dir);
        return dir ? (sel - 2'd1) : (sel + 2'd1);
    endfunction

endpackage

// File: rtl/seq_dwell_counter.sv
// Counts counter wraps; done pulses together with the DWELL-th tick.
module seq_dwell_counter #(
    parameter int unsigned DWELL = 4
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] dwell_cnt_q, dwell_cnt_d;

    assign done = tick && (dwell_cnt_q == LAST);

    // Next dwell count: clear wins, otherwise roll over on the final tick.
    always_comb begin
        dwell_cnt_d = dwell_cnt_q;
        if (clr) begin
            dwell_cnt_d = '0;
        end else if (tick) begin
            dwell_cnt_d = done ? '0 : dwell_cnt_q + CW'(1);
        end
    end

    // Dwell count register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            dwell_cnt_q <= '0;
        end else begin
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

endmodule

// File: rtl/blink_sequencer.sv
// Sequences the external LED counter and walks the 2-bit LED tap select.
module blink_sequencer
    import blink_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    input  logic [WIDTH-1:0] count,
    output logic             count_en,
    output logic             count_clr,
    output logic [1:0]       sel,
    output logic             led,
    output logic             adv,
    output logic [1:0]       state
);

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       adv_q, adv_d;
    logic       wrap;
    logic       dwell_tick;
    logic       dwell_clr;
    logic       dwell_done;
    logic [3:0] taps;

    assign wrap = (count == {WIDTH{1'b1}});

    seq_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .sysclk (sysclk),
        .reset  (reset),
        .clr    (dwell_clr),
        .tick   (dwell_tick),
        .done   (dwell_done)
    );

    // Next state, select and advance pulse; stop > hold > start > step.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        adv_d      = 1'b0;
        dwell_tick = 1'b0;
        dwell_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                dwell_clr = 1'b1;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    // A wrap coinciding with stop is dropped.
                    state_d   = S_IDLE;
                    dwell_clr = 1'b1;
                end else begin
                    dwell_tick = wrap;
                    if (dwell_done) begin
                        sel_d = sel_next(sel_q, dir);
                        adv_d = 1'b1;
                    end
                    if (hold) state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    dwell_clr = 1'b1;
                end else if (hold) begin
                    state_d = S_PAUSE;
                end else if (start) begin
                    state_d = S_RUN;
                end else if (step) begin
                    sel_d     = sel_next(sel_q, dir);
                    adv_d     = 1'b1;
                    dwell_clr = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                dwell_clr = 1'b1;
            end
        endcase
    end

    // State, select and advance-pulse registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            adv_q   <= adv_d;
        end
    end

    assign count_en  = (state_q == S_RUN);
    assign count_clr = (state_q == S_IDLE);
    assign sel       = sel_q;
    assign adv       = adv_q;
    assign state     = state_q;

    // Top four counter bits are the selectable LED taps.
    assign taps = count[WIDTH-1 -: 4];
    assign led  = taps[sel_q];

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench: blink_sequencer (WIDTH=4, DWELL=2) driving a simple counter model.
module tb_blink_sequencer;

    logic       sysclk = 1'b0;
    logic       reset, start, hold, stop, step, dir;
    logic [3:0] cnt = 4'd0;
    logic       count_en, count_clr, led, adv;
    logic [1:0] sel, state;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_sel;
    logic [3:0] exp_cnt;

    always #5 sysclk = ~sysclk;

    // External free-running counter with synchronous clear.
    always @(posedge sysclk) begin
        if (count_clr) cnt <= 4'd0;
        else if (count_en) cnt <= cnt + 4'd1;
    end

    blink_sequencer #(
        .WIDTH (4),
        .DWELL (2)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .start     (start),
        .hold      (hold),
        .stop      (stop),
        .step      (step),
        .dir       (dir),
        .count     (cnt),
        .count_en  (count_en),
        .count_clr (count_clr),
        .sel       (sel),
        .led       (led),
        .adv       (adv),
        .state     (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; stop = 1'b0; step = 1'b0; dir = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_clr", 32'(count_clr), 32'd1);
        chk("rst_en", 32'(count_en), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_adv", 32'(adv), 32'd0);
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk("idle_cnt", 32'(cnt), 32'd0);
        end

        // Free-run up.
        dir = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("run_state", 32'(state), 32'd1);
        chk("run_en", 32'(count_en), 32'd1);
        chk("run_cnt0", 32'(cnt), 32'd0);
        for (int k = 1; k <= 165; k++) begin
            cyc(1);
            exp_sel = 2'((k / 32) % 4);
            exp_cnt = 4'(k % 16);
            chk("up_cnt", 32'(cnt), 32'(exp_cnt));
            chk("up_sel", 32'(sel), 32'(exp_sel));
            chk("up_adv", 32'(adv), 32'(k % 32 == 0));
            chk("up_led", 32'(led), 32'(exp_cnt[exp_sel]));
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_sel", 32'(sel), 32'd1);
        chk("stop_clr", 32'(count_clr), 32'd1);
        cyc(1);
        chk("stop_cnt", 32'(cnt), 32'd0);

        // Direction down from sel=0.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("dn_sel0", 32'(sel), 32'd0);
        dir = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            cyc(1);
            exp_sel = 2'((4 - (k / 32) % 4) % 4);
            chk("dn_sel", 32'(sel), 32'(exp_sel));
            chk("dn_adv", 32'(adv), 32'(k % 32 == 0));
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);

        // Pause after one wrap, at count=7; step clears dwell.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; dir = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(22);
        chk("p_cnt6", 32'(cnt), 32'd6);
        hold = 1'b1;
        cyc(1);
        chk("p_state", 32'(state), 32'd2);
        chk("p_cnt7", 32'(cnt), 32'd7);
        chk("p_en", 32'(count_en), 32'd0);
        cyc(1);
        hold = 1'b0;
        chk("p_hold", 32'(state), 32'd2);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("p_frz_cnt", 32'(cnt), 32'd7);
            chk("p_frz_en", 32'(count_en), 32'd0);
        end
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step_sel", 32'(sel), 32'd1);
        chk("step_adv", 32'(adv), 32'd1);
        chk("step_state", 32'(state), 32'd2);
        cyc(1);
        chk("step_adv0", 32'(adv), 32'd0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("res_state", 32'(state), 32'd1);
        chk("res_cnt", 32'(cnt), 32'd7);
        for (int k = 1; k <= 25; k++) begin
            cyc(1);
            chk("res_adv", 32'(adv), 32'(k == 25));
            chk("res_sel", 32'(sel), (k == 25) ? 32'd2 : 32'd1);
        end

        // Stop on a wrap whose dwell has expired.
        cyc(31);
        chk("sw_cnt", 32'(cnt), 32'd15);
        chk("sw_sel_pre", 32'(sel), 32'd2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("sw_state", 32'(state), 32'd0);
        chk("sw_sel", 32'(sel), 32'd2);
        chk("sw_adv", 32'(adv), 32'd0);
        chk("sw_clr", 32'(count_clr), 32'd1);
        cyc(1);
        chk("sw_cnt0", 32'(cnt), 32'd0);

        // Hold on a wrap whose dwell has expired.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(31);
        chk("hw_cnt", 32'(cnt), 32'd15);
        chk("hw_sel_pre", 32'(sel), 32'd2);
        hold = 1'b1;
        cyc(1);
        hold = 1'b0;
        chk("hw_sel", 32'(sel), 32'd3);
        chk("hw_adv", 32'(adv), 32'd1);
        chk("hw_state", 32'(state), 32'd2);
        chk("hw_en", 32'(count_en), 32'd0);
        chk("hw_cnt0", 32'(cnt), 32'd0);
        cyc(1);
        chk("hw_adv0", 32'(adv), 32'd0);
        chk("hw_state2", 32'(state), 32'd2);

        // Step down to sel=2, run, then reset mid-RUN.
        dir = 1'b1; step = 1'b1;
        cyc(1);
        step = 1'b0; dir = 1'b0;
        chk("sd_sel", 32'(sel), 32'd2);
        chk("sd_adv", 32'(adv), 32'd1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        chk("mr_state", 32'(state), 32'd1);
        chk("mr_cnt", 32'(cnt), 32'd3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mr_sel", 32'(sel), 32'd0);
        chk("mr_state0", 32'(state), 32'd0);
        chk("mr_clr", 32'(count_clr), 32'd1);
        chk("mr_adv", 32'(adv), 32'd0);
        cyc(1);
        chk("mr_cnt0", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
